// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/add/sub/rotate and an iterative
// shift-add multiply that holds Busy for WIDTH cycles before pulsing Done.
module alu_multicycle #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [3:0]       Operacioni,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Invalid,
    output logic             Busy,
    output logic             Done,
    output logic             o_dbg_state
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_ROR  = 4'b0110;
    localparam logic [3:0] OP_MUL  = 4'b0111;
    localparam logic [3:0] OP_SUB  = 4'b1100;
    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t r_state, w_state_next;
    logic             w_mul_last;

    logic [WIDTH-1:0]   r_result;
    logic               r_zero, r_carry, r_ovf, r_inv, r_busy, r_done;
    logic [2*WIDTH-1:0] r_acc, r_mcand, w_acc_next;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW:0]       r_cnt;

    logic [WIDTH:0]     w_sum, w_diff;
    logic [2*WIDTH-1:0] w_ror_wide;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_carry, w_alu_ovf, w_alu_inv;

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_mul_last   = 1'b0;
        case (r_state)
            S_IDLE: if (Start && Operacioni == OP_MUL) w_state_next = S_MUL;
            S_MUL: begin
                if (r_cnt == CNT_LAST) begin
                    w_mul_last   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Single-cycle datapath evaluates the live inputs; it is captured only on an accepted Start.
    assign w_sum      = {1'b0, A} + {1'b0, B};
    assign w_diff     = {1'b0, A} - {1'b0, B};
    assign w_ror_wide = {A, A} >> B[SHW-1:0];
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        w_alu_ovf    = 1'b0;
        w_alu_inv    = 1'b0;
        case (Operacioni)
            OP_AND: w_alu_result = A & B;
            OP_OR:  w_alu_result = A | B;
            OP_XOR: w_alu_result = A ^ B;
            OP_ADD, OP_ADDI: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
                w_alu_ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_alu_result = w_diff[WIDTH-1:0];
                w_alu_carry  = w_diff[WIDTH];
                w_alu_ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ROR: w_alu_result = w_ror_wide[WIDTH-1:0];
            OP_MUL: w_alu_result = '0;
            default: w_alu_inv = 1'b1;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_inv    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE && Start) begin
                if (Operacioni == OP_MUL) begin
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, A};
                    r_mplier <= B;
                    r_busy   <= 1'b1;
                end else begin
                    r_result <= w_alu_result;
                    r_zero   <= (w_alu_result == '0);
                    r_carry  <= w_alu_carry;
                    r_ovf    <= w_alu_ovf;
                    r_inv    <= w_alu_inv;
                    r_done   <= 1'b1;
                end
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_next;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
                // Final iteration publishes the accumulator including this edge's partial product.
                if (w_mul_last) begin
                    r_result <= w_acc_next[WIDTH-1:0];
                    r_zero   <= (w_acc_next[WIDTH-1:0] == '0);
                    r_ovf    <= |w_acc_next[2*WIDTH-1:WIDTH];
                    r_carry  <= 1'b0;
                    r_inv    <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign Result      = r_result;
    assign Zero        = r_zero;
    assign Carry       = r_carry;
    assign Overflow    = r_ovf;
    assign Invalid     = r_inv;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: vector table for single-cycle ops, hand-written
// sequences for multiply latency, ignored Start, back-to-back and reset abort.
module tb_alu_multicycle;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Operacioni = 4'b0;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [15:0] Result;
    logic        Zero, Carry, Overflow, Invalid, Busy, Done, dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [15:0] a, b, res;
        logic        z, c, v, inv;
    } vec_t;

    vec_t vecs[13];

    alu_multicycle #(.WIDTH(16), .SHW(4)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Operacioni(Operacioni),
        .A(A), .B(B), .Result(Result), .Zero(Zero), .Carry(Carry),
        .Overflow(Overflow), .Invalid(Invalid), .Busy(Busy), .Done(Done),
        .o_dbg_state(dbg_state)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; issues one single-cycle op and checks after its edge.
    task automatic do_op(input string name, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic z,
                         input logic c, input logic v, input logic inv);
        Start = 1'b1; Operacioni = op; A = a; B = b;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        check({name, ".done"}, 32'(Done), 32'd1);
        check({name, ".busy"}, 32'(Busy), 32'd0);
        check({name, ".res"},  32'(Result), 32'(res));
        check({name, ".flags"}, {28'd0, Zero, Carry, Overflow, Invalid}, {28'd0, z, c, v, inv});
    endtask

    // Called at a negedge; runs a multiply, optionally injecting an ADD Start mid-flight.
    // Returns at the negedge where Done is observed.
    task automatic mul_run(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] res, input logic v, input bit inject);
        int cycles;
        int busy_cnt;
        cycles = 0;
        busy_cnt = 0;
        Start = 1'b1; Operacioni = 4'b0111; A = a; B = b;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        check({name, ".state"}, 32'(dbg_state), 32'd1);
        while (!Done && cycles < 40) begin
            if (Busy) busy_cnt++;
            if (inject && cycles == 5) begin
                Start = 1'b1; Operacioni = 4'b0100; A = 16'h0001; B = 16'h0002;
            end else if (inject && cycles == 6) begin
                Start = 1'b0; A = 16'hAAAA; B = 16'h5555;
            end
            @(negedge Clock);
            cycles++;
        end
        Start = 1'b0;
        check({name, ".latency"}, 32'(cycles), 32'd16);
        check({name, ".busy_cycles"}, 32'(busy_cnt), 32'd16);
        check({name, ".done"}, 32'(Done), 32'd1);
        check({name, ".busy_end"}, 32'(Busy), 32'd0);
        check({name, ".res"}, 32'(Result), 32'(res));
        check({name, ".flags"}, {28'd0, Zero, Carry, Overflow, Invalid},
              {28'd0, (res == 16'h0), 1'b0, v, 1'b0});
    endtask

    initial begin
        vecs[0]  = '{"add_ovf",   4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 0};
        vecs[1]  = '{"sub_borrow",4'b1100, 16'h0003, 16'h0005, 16'hFFFE, 0, 1, 0, 0};
        vecs[2]  = '{"xor_zero",  4'b0011, 16'hFFFF, 16'hFFFF, 16'h0000, 1, 0, 0, 0};
        vecs[3]  = '{"ror_1",     4'b0110, 16'h0001, 16'h0011, 16'h8000, 0, 0, 0, 0};
        vecs[4]  = '{"ror_0",     4'b0110, 16'h1234, 16'h0000, 16'h1234, 0, 0, 0, 0};
        vecs[5]  = '{"inv_f",     4'b1111, 16'h1234, 16'h5678, 16'h0000, 1, 0, 0, 1};
        vecs[6]  = '{"and",       4'b0000, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 0};
        vecs[7]  = '{"or",        4'b0010, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0, 0};
        vecs[8]  = '{"addi_carry",4'b0101, 16'hFFFF, 16'h0001, 16'h0000, 1, 1, 0, 0};
        vecs[9]  = '{"sub_ovf",   4'b1100, 16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1, 0};
        vecs[10] = '{"ror_4",     4'b0110, 16'h00F1, 16'h0004, 16'h100F, 0, 0, 0, 0};
        vecs[11] = '{"inv_1",     4'b0001, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0, 1};
        vecs[12] = '{"add_both",  4'b0100, 16'h8000, 16'h8000, 16'h0000, 1, 1, 1, 0};

        repeat (2) @(negedge Clock);
        check("reset.outs", {Result, 9'd0, Zero, Carry, Overflow, Invalid, Busy, Done, dbg_state},
              32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset.idle_done", 32'(Done), 32'd0);

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res,
                  vecs[i].z, vecs[i].c, vecs[i].v, vecs[i].inv);

        @(negedge Clock);
        check("hold.done", 32'(Done), 32'd0);
        check("hold.res", 32'(Result), 32'h0000);
        check("hold.inv", 32'(Invalid), 32'd0);

        mul_run("mul_12x34", 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b0);
        @(negedge Clock);
        mul_run("mul_ovf", 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
        @(negedge Clock);
        mul_run("mul_inject", 16'h0012, 16'h0034, 16'h03A8, 1'b0, 1'b1);
        do_op("b2b_add", 4'b0100, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 0);

        // Reset lands on edge k+7 of a multiply.
        @(negedge Clock);
        Start = 1'b1; Operacioni = 4'b0111; A = 16'h00FF; B = 16'h00FF;
        @(posedge Clock);
        @(negedge Clock);
        Start = 1'b0;
        repeat (6) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        check("abort.busy", 32'(Busy), 32'd0);
        check("abort.res", 32'(Result), 32'd0);
        check("abort.done", 32'(Done), 32'd0);
        check("abort.state", 32'(dbg_state), 32'd0);
        Reset = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            repeat (20) begin
                @(negedge Clock);
                if (Done) seen_done++;
            end
            check("abort.no_done", 32'(seen_done), 32'd0);
        end
        mul_run("mul_after_rst", 16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0);
        @(negedge Clock);
        do_op("add_after_rst", 4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
16-bit execute-stage ALU. Sits directly downstream of the ALU control decoder and consumes its 4-bit Operacioni code plus the two register operands. Logic, add, sub and rotate complete in one cycle. Multiply runs as an iterative shift-add over WIDTH cycles, under a Start/Busy/Done handshake that lets the control FSM stall.

Parameters:
WIDTH, 16, operand/result width in bits; multiply iteration count equals WIDTH
SHW, 4, rotate-amount width, equal to clog2(WIDTH); rotate uses B[SHW-1:0]

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
Start  in  1  request; sampled only in IDLE
Operacioni  in  4  operation code from ALU control
A  in  WIDTH  operand A (rs)
B  in  WIDTH  operand B (rt or immediate)
Result  out  WIDTH  registered result
Zero  out  1  Result == 0
Carry  out  1  add: carry-out; sub: borrow (A < B unsigned); otherwise 0
Overflow  out  1  add/sub: signed overflow; mul: upper WIDTH bits of product nonzero; otherwise 0
Invalid  out  1  Operacioni was not a defined code
Busy  out  1  multiply in progress
Done  out  1  one-cycle pulse: Result and flags updated

Behaviour:
- Op codes:
  - 0000 AND, 0010 OR, 0011 XOR
  - 0100 ADD, 0101 ADDI (identical to ADD), 1100 SUB (A-B)
  - 0110 ROR: rotate A right by B[SHW-1:0]; amount 0 returns A
  - 0111 MUL: unsigned; Result = low WIDTH bits of product
  - Any other code: Result=0, Zero=1, Carry=0, Overflow=0, Invalid=1, completes in one cycle.
- Reset (priority over everything):
  - Result=0, Zero=0, Carry=0, Overflow=0, Invalid=0, Busy=0, Done=0.
  - State=IDLE; multiply counter and accumulator cleared.
  - Reset during MUL aborts the multiply; no Done pulse is produced.
- States: IDLE, MUL.
- IDLE, Start=1 at edge k:
  - A, B and Operacioni are latched internally.
  - Non-MUL: Result and all flags written at edge k; Done=1 for the cycle after edge k. State stays IDLE.
  - MUL: accumulator (2*WIDTH bits) cleared, counter=0, state goes to MUL; Busy=1 from edge k.
- MUL state, each edge:
  - If multiplier LSB=1, add the shifted multiplicand into the accumulator; shift multiplier right and multiplicand left; counter++.
  - At the edge where counter reaches WIDTH (edge k+WIDTH; k+16 at default):
    - Result = acc[WIDTH-1:0]; Overflow = |acc[2*WIDTH-1:WIDTH]; Zero per Result; Carry=0; Invalid=0.
    - Done=1 for one cycle, Busy=0, state goes to IDLE.
- Busy is high for exactly WIDTH cycles per multiply.
- Start while Busy=1 is ignored; it is neither queued nor latched.
- Changes on A, B and Operacioni after the Start edge have no effect on the operation in flight.
- Back-to-back: Start is accepted in the same cycle Done is high, since state is IDLE.
- Result and flags hold their last values between operations.
- Done is 0 whenever no completion occurred on the previous edge.
- Add carry: bit WIDTH of the (WIDTH+1)-bit sum.
- Signed overflow:
  - add: operands share a sign and the sign of Result differs.
  - sub: operand signs differ and the sign of Result differs from A.

Test Plan:
- Reset, then ADD A=0x7FFF B=0x0001 with Start pulse -> next cycle Done=1, Result=0x8000, Carry=0, Overflow=1, Zero=0, Busy never asserted.
- SUB A=0x0003 B=0x0005 -> Result=0xFFFE, Carry=1, Overflow=0. Then XOR 0xFFFF^0xFFFF -> Result=0x0000, Zero=1.
- ROR A=0x0001 B=0x0011 -> Result=0x8000 (amount 1). ROR with B=0x0000 -> Result=A. Code 1111 -> Result=0, Invalid=1, Done after 1 cycle.
- MUL A=0x0012 B=0x0034, Start at edge k -> Busy high 16 cycles, Done only after edge k+16, Result=0x03A8, Overflow=0. MUL 0x0100*0x0100 -> Result=0x0000, Zero=1, Overflow=1.
- During MUL, pulse Start with ADD and change A/B -> ignored, MUL result unchanged. Start ADD in the Done cycle -> accepted, completes the following cycle.
- Reset asserted at edge k+7 of a MUL -> Busy=0, Result=0, no Done pulse. Next Start behaves as from a fresh reset.
